pulse_gen: RTL

PULSE_GEN -- requirements
Module: pulse_gen

---
 rtl/pulse_gen_pkg.sv | 14 +
 rtl/pulse_down_counter.sv | 39 +++
 rtl/pulse_gen.sv | 136 +++++++++++++
 3 files changed

// File: rtl/pulse_gen_pkg.sv
// pulse_gen_pkg
//   Shared definitions for the pulse generator: FSM state encoding and the
//   default counter width used by pulse_gen and pulse_down_counter.
package pulse_gen_pkg;

   localparam int CNT_W_DEF = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PULSE = 2'd1,
      ST_GUARD = 2'd2
   } state_t;

endpackage

// File: rtl/pulse_down_counter.sv
// pulse_down_counter
//   Loadable down-counter shared by the PULSE and GUARD phases. Load has
//   priority over decrement; decrement saturates at zero so the counter
//   never wraps.
// Ports:
//   i_clk       clock, rising edge
//   i_rst       synchronous active-high reset, clears count to 0
//   i_load      load i_load_val
//   i_dec       decrement by one (ignored when already zero)
//   i_load_val  value to load
//   o_zero      count is zero (decoded from the register)
module pulse_down_counter
   import pulse_gen_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_load,
   input  logic             i_dec,
   input  logic [CNT_W-1:0] i_load_val,
   output logic             o_zero
);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (i_dec && (r_cnt != '0)) begin
         r_cnt <= r_cnt - CNT_W'(1);
      end
   end

   assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/pulse_gen.sv
// pulse_gen
//   Single-shot pulse generator: an accepted start produces a pulse of
//   pulse_width cycles followed by a low guard of guard_len cycles. Dropping
//   enable during the pulse cuts it short (aborted strobe) and still runs the
//   guard. All outputs are registered.
// Ports:
//   CLK          clock, rising edge
//   RST          synchronous active-high reset
//   enable       generator enable; low aborts a pulse and blocks new starts
//   start        one-cycle request, only honoured in IDLE
//   pulse_width  high time in cycles (0 = request ignored)
//   guard_len    low recovery time after the falling edge
//   pulse_out    generated pulse
//   busy         high during PULSE and GUARD
//   done         strobe on the first low cycle after a complete pulse
//   aborted      strobe on the first low cycle after an aborted pulse
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start; outputs low
// PULSE  | pulse_out high; counter counts remaining high cycles - 1
// GUARD  | pulse_out low, busy high; counter counts remaining guard - 1
module pulse_gen
   import pulse_gen_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             enable,
   input  logic             start,
   input  logic [CNT_W-1:0] pulse_width,
   input  logic [CNT_W-1:0] guard_len,
   output logic             pulse_out,
   output logic             busy,
   output logic             done,
   output logic             aborted
);

   state_t           r_state;
   logic [CNT_W-1:0] r_guard;
   logic             r_pulse;
   logic             r_busy;
   logic             r_done;
   logic             r_aborted;

   logic             w_accept;
   logic             w_end_pulse;
   logic             w_load;
   logic             w_dec;
   logic [CNT_W-1:0] w_load_val;
   logic             w_zero;

   assign w_accept    = (r_state == ST_IDLE) && enable && start && (pulse_width != '0);
   // Pulse ends on its last counted cycle or immediately when enable drops.
   assign w_end_pulse = (r_state == ST_PULSE) && (!enable || w_zero);

   // Counter control: load W-1 on accept, G-1 at pulse end (0 when no guard).
   always_comb begin
      w_load     = 1'b0;
      w_dec      = 1'b0;
      w_load_val = '0;
      if (w_accept) begin
         w_load     = 1'b1;
         w_load_val = pulse_width - CNT_W'(1);
      end else if (w_end_pulse) begin
         w_load     = 1'b1;
         w_load_val = (r_guard != '0) ? (r_guard - CNT_W'(1)) : '0;
      end else if ((r_state == ST_PULSE) || (r_state == ST_GUARD)) begin
         w_dec = 1'b1;
      end
   end

   pulse_down_counter #(.CNT_W(CNT_W)) u_cnt (
      .i_clk      (CLK),
      .i_rst      (RST),
      .i_load     (w_load),
      .i_dec      (w_dec),
      .i_load_val (w_load_val),
      .o_zero     (w_zero)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state   <= ST_IDLE;
         r_guard   <= '0;
         r_pulse   <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_aborted <= 1'b0;
      end else begin
         r_done    <= 1'b0;
         r_aborted <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_state <= ST_PULSE;
                  r_guard <= guard_len;
                  r_pulse <= 1'b1;
                  r_busy  <= 1'b1;
               end
            end
            ST_PULSE: begin
               if (w_end_pulse) begin
                  r_pulse   <= 1'b0;
                  r_done    <= enable;
                  r_aborted <= !enable;
                  if (r_guard != '0) begin
                     r_state <= ST_GUARD;
                  end else begin
                     r_state <= ST_IDLE;
                     r_busy  <= 1'b0;
                  end
               end
            end
            ST_GUARD: begin
               if (w_zero) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_pulse <= 1'b0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign pulse_out = r_pulse;
   assign busy      = r_busy;
   assign done      = r_done;
   assign aborted   = r_aborted;

endmodule
